// File: rtl/sensor_cfg_pkg.sv
// Shared definitions for the sensor configuration sequencer: state encoding,
// table entry field positions and the delay-op register marker.
package sensor_cfg_pkg;

  localparam int unsigned ENTRY_W  = 16;
  localparam int unsigned REG_MSB  = 15;
  localparam int unsigned REG_LSB  = 8;
  localparam int unsigned DATA_MSB = 7;
  localparam int unsigned DATA_LSB = 0;

  localparam logic [7:0] DELAY_OP_REG = 8'hFF;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_FETCH = 4'd1;
  localparam logic [3:0] ST_LATCH = 4'd2;
  localparam logic [3:0] ST_ISSUE = 4'd3;
  localparam logic [3:0] ST_WAIT  = 4'd4;
  localparam logic [3:0] ST_GAP   = 4'd5;
  localparam logic [3:0] ST_DONE  = 4'd6;
  localparam logic [3:0] ST_ERROR = 4'd7;

  typedef enum logic [3:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_LATCH = ST_LATCH,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_GAP   = ST_GAP,
    S_DONE  = ST_DONE,
    S_ERROR = ST_ERROR
  } cfg_state_e;

  // Counter width helper; never returns less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sensor_cfg_rom.sv
// Synchronous configuration table ROM; entry 0 sits in the LSBs of TABLE.
// Output is valid one cycle after tbl_index changes.
module sensor_cfg_rom
  import sensor_cfg_pkg::*;
#(
  parameter int unsigned                          IDX_W = 4,
  parameter logic [ENTRY_W*(2**IDX_W)-1:0]        TABLE = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IDX_W-1:0]   tbl_index,
  output logic [ENTRY_W-1:0] tbl_entry
);

  logic [ENTRY_W-1:0] r_entry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_entry <= '0;
    end else begin
      r_entry <= TABLE[ENTRY_W*tbl_index +: ENTRY_W];
    end
  end

  assign tbl_entry = r_entry;

endmodule

// File: rtl/sensor_cfg_sequencer.sv
// Walks the configuration table and issues each entry as one I2C register
// write with gap, retry and watchdog. Optional SENSOR_CFG_DELAY_OP_EN turns
// reg_address 8'hFF entries into data*256-cycle pauses.
module sensor_cfg_sequencer
  import sensor_cfg_pkg::*;
#(
  parameter logic [5:0]  DEV_ADDR     = 6'h29,
  parameter int unsigned NUM_ENTRIES  = 16,
  parameter int unsigned IDX_W        = 4,
  parameter int unsigned MAX_RETRIES  = 3,
  parameter int unsigned GAP_CYCLES   = 1000,
  parameter int unsigned WAIT_TIMEOUT = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  output logic [IDX_W-1:0]   tbl_index,
  input  logic [ENTRY_W-1:0] tbl_entry,
  output logic [5:0]         wr_dev_address,
  output logic [7:0]         wr_reg_address,
  output logic [7:0]         wr_data,
  output logic               wr_start,
  input  logic               wr_done,
  input  logic               wr_failure,
  output logic               busy,
  output logic               config_done,
  output logic               config_error,
  output logic [IDX_W-1:0]   err_index,
  output logic [3:0]         state_out
);

  localparam int unsigned GAP_W  = cnt_width(GAP_CYCLES);
  localparam int unsigned WAIT_W = cnt_width(WAIT_TIMEOUT);
  localparam int unsigned RTY_W  = cnt_width(MAX_RETRIES);
`ifdef SENSOR_CFG_DELAY_OP_EN
  // The watchdog doubles as the delay-op timer (up to 255*256 cycles).
  localparam int unsigned WDOG_W = (WAIT_W > 16) ? WAIT_W : 16;
`else
  localparam int unsigned WDOG_W = WAIT_W;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  cfg_state_e        r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [RTY_W-1:0]  r_retry, w_retry_nxt;
  logic [GAP_W-1:0]  r_gap, w_gap_nxt;
  logic [WDOG_W-1:0] r_wdog, w_wdog_nxt;
  logic              r_reissue, w_reissue_nxt;
  logic [5:0]        r_dev, w_dev_nxt;
  logic [7:0]        r_reg, w_reg_nxt;
  logic [7:0]        r_data, w_data_nxt;
  logic              r_start, w_start_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_error, w_error_nxt;
  logic [IDX_W-1:0]  r_err_idx, w_err_idx_nxt;
  logic              w_ok, w_fail;
`ifdef SENSOR_CFG_DELAY_OP_EN
  logic              r_delay, w_delay_nxt;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_retry   <= '0;
      r_gap     <= '0;
      r_wdog    <= '0;
      r_reissue <= 1'b0;
      r_dev     <= '0;
      r_reg     <= '0;
      r_data    <= '0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_err_idx <= '0;
`ifdef SENSOR_CFG_DELAY_OP_EN
      r_delay   <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_retry   <= w_retry_nxt;
      r_gap     <= w_gap_nxt;
      r_wdog    <= w_wdog_nxt;
      r_reissue <= w_reissue_nxt;
      r_dev     <= w_dev_nxt;
      r_reg     <= w_reg_nxt;
      r_data    <= w_data_nxt;
      r_start   <= w_start_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
      r_err_idx <= w_err_idx_nxt;
`ifdef SENSOR_CFG_DELAY_OP_EN
      r_delay   <= w_delay_nxt;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_retry_nxt   = r_retry;
    w_gap_nxt     = r_gap;
    w_wdog_nxt    = r_wdog;
    w_reissue_nxt = r_reissue;
    w_dev_nxt     = r_dev;
    w_reg_nxt     = r_reg;
    w_data_nxt    = r_data;
    w_done_nxt    = r_done;
    w_error_nxt   = r_error;
    w_err_idx_nxt = r_err_idx;
    w_ok          = 1'b0;
    w_fail        = 1'b0;
`ifdef SENSOR_CFG_DELAY_OP_EN
    w_delay_nxt   = r_delay;
`endif

    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (go) begin
          w_done_nxt    = 1'b0;
          w_error_nxt   = 1'b0;
          w_err_idx_nxt = '0;
          w_idx_nxt     = '0;
          w_retry_nxt   = '0;
          w_state_nxt   = S_FETCH;
        end
      end
      S_FETCH: w_state_nxt = S_LATCH;
      S_LATCH: begin
        w_dev_nxt   = DEV_ADDR;
        w_reg_nxt   = tbl_entry[REG_MSB:REG_LSB];
        w_data_nxt  = tbl_entry[DATA_MSB:DATA_LSB];
        w_state_nxt = S_ISSUE;
`ifdef SENSOR_CFG_DELAY_OP_EN
        w_delay_nxt = 1'b0;
        if (tbl_entry[REG_MSB:REG_LSB] == DELAY_OP_REG) begin
          w_delay_nxt = 1'b1;
          w_wdog_nxt  = WDOG_W'({tbl_entry[DATA_MSB:DATA_LSB], 8'h00});
          w_state_nxt = S_WAIT;
        end
`endif
      end
      S_ISSUE: begin
        w_wdog_nxt  = WDOG_W'(WAIT_TIMEOUT);
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
`ifdef SENSOR_CFG_DELAY_OP_EN
        if (r_delay) begin
          if (r_wdog <= WDOG_W'(1)) w_ok = 1'b1;
          else                      w_wdog_nxt = r_wdog - WDOG_W'(1);
        end else
`endif
        // wr_done takes priority over a watchdog expiring in the same cycle
        if (wr_done) begin
          w_ok   = !wr_failure;
          w_fail = wr_failure;
        end else if (r_wdog == WDOG_W'(1)) begin
          w_fail = 1'b1;
        end else begin
          w_wdog_nxt = r_wdog - WDOG_W'(1);
        end

        if (w_ok) begin
          if (r_idx == LAST_IDX) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt     = r_idx + IDX_W'(1);
            w_retry_nxt   = '0;
            w_gap_nxt     = GAP_W'(GAP_CYCLES);
            w_reissue_nxt = 1'b0;
            w_state_nxt   = S_GAP;
          end
        end else if (w_fail) begin
          if (r_retry < RTY_W'(MAX_RETRIES)) begin
            w_retry_nxt   = r_retry + RTY_W'(1);
            w_gap_nxt     = GAP_W'(GAP_CYCLES);
            w_reissue_nxt = 1'b1;
            w_state_nxt   = S_GAP;
          end else begin
            w_error_nxt   = 1'b1;
            w_err_idx_nxt = r_idx;
            w_state_nxt   = S_ERROR;
          end
        end
      end
      S_GAP: begin
        if (r_gap <= GAP_W'(1)) begin
          w_gap_nxt   = '0;
          w_state_nxt = r_reissue ? S_ISSUE : S_FETCH;
        end else begin
          w_gap_nxt = r_gap - GAP_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Registered outputs follow the state being entered
    w_start_nxt = (w_state_nxt == S_ISSUE);
    w_busy_nxt  = !((w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE) ||
                    (w_state_nxt == S_ERROR));
  end

  assign tbl_index      = r_idx;
  assign wr_dev_address = r_dev;
  assign wr_reg_address = r_reg;
  assign wr_data        = r_data;
  assign wr_start       = r_start;
  assign busy           = r_busy;
  assign config_done    = r_done;
  assign config_error   = r_error;
  assign err_index      = r_err_idx;
  assign state_out      = r_state;

endmodule

// File: tb/tb_sensor_cfg_sequencer.sv
// Directed bench for sensor_cfg_sequencer with a three-entry table and a
// behavioural i2c_write_reg responder (programmable ack delay and failures).
module tb_sensor_cfg_sequencer;

  localparam int unsigned IDX_W = 4;
  localparam logic [16*16-1:0] TABLE = {208'h0, 16'h6B02, 16'h6A01, 16'h6973};

  logic             clk;
  logic             reset;
  logic             go;
  logic [IDX_W-1:0] tbl_index;
  logic [15:0]      tbl_entry;
  logic [5:0]       wr_dev_address;
  logic [7:0]       wr_reg_address;
  logic [7:0]       wr_data;
  logic             wr_start;
  logic             wr_done;
  logic             wr_failure;
  logic             busy;
  logic             config_done;
  logic             config_error;
  logic [IDX_W-1:0] err_index;
  logic [3:0]       state_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int go_cyc = 0;

  int         n_starts = 0;
  int         start_cyc [16];
  logic [7:0] start_reg [16];
  logic [7:0] start_data[16];
  int         fail_left [3];
  int         ack_delay = 10;
  bit         never_ack = 1'b0;
  int         ack_cnt = -1;
  int         cur_entry = 0;

  sensor_cfg_sequencer #(
    .DEV_ADDR(6'h29), .NUM_ENTRIES(3), .IDX_W(IDX_W), .MAX_RETRIES(3),
    .GAP_CYCLES(4), .WAIT_TIMEOUT(50)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .tbl_index(tbl_index),
    .tbl_entry(tbl_entry), .wr_dev_address(wr_dev_address),
    .wr_reg_address(wr_reg_address), .wr_data(wr_data), .wr_start(wr_start),
    .wr_done(wr_done), .wr_failure(wr_failure), .busy(busy),
    .config_done(config_done), .config_error(config_error),
    .err_index(err_index), .state_out(state_out)
  );

  sensor_cfg_rom #(.IDX_W(IDX_W), .TABLE(TABLE)) u_rom (
    .clk(clk), .reset(reset), .tbl_index(tbl_index), .tbl_entry(tbl_entry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // i2c_write_reg model plus wr_start logger, evaluated mid-cycle
  initial begin
    wr_done = 1'b0;
    wr_failure = 1'b0;
    forever begin
      @(negedge clk);
      wr_done = 1'b0;
      wr_failure = 1'b0;
      if (ack_cnt > 0) ack_cnt--;
      if (ack_cnt == 0) begin
        wr_done = 1'b1;
        if (cur_entry >= 0 && cur_entry < 3 && fail_left[cur_entry] > 0) begin
          wr_failure = 1'b1;
          fail_left[cur_entry]--;
        end
        ack_cnt = -1;
      end
      if (wr_start === 1'b1) begin
        if (n_starts < 16) begin
          start_cyc[n_starts]  = cyc;
          start_reg[n_starts]  = wr_reg_address;
          start_data[n_starts] = wr_data;
        end
        n_starts++;
        cur_entry = int'(wr_reg_address) - 'h69;
        if (!never_ack) ack_cnt = ack_delay;
      end
    end
  end

  task automatic setup(input int f0, input int f1, input int f2);
    n_starts = 0;
    fail_left[0] = f0;
    fail_left[1] = f1;
    fail_left[2] = f2;
  endtask

  task automatic pulse_go();
    @(negedge clk);
    go = 1'b1;
    go_cyc = cyc;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int k;
    k = 0;
    while (!(config_done === 1'b1 || config_error === 1'b1) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 3000) begin
      errors++;
      $display("FAIL %s_finish: no config_done/config_error after %0d cycles", name, k);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({wr_start, busy, config_done, config_error} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {wr_start, busy, config_done, config_error});
    end
    checks++;
    if (state_out !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_out); end
    checks++;
    if (tbl_index !== 4'd0 || err_index !== 4'd0) begin
      errors++; $display("FAIL reset_index: tbl_index %0d err_index %0d expected 0", tbl_index, err_index);
    end
    checks++;
    if ({wr_dev_address, wr_reg_address, wr_data} !== 22'd0) begin
      errors++; $display("FAIL reset_wrbus: got %h expected 0", {wr_dev_address, wr_reg_address, wr_data});
    end
  endtask

  task automatic test_basic();
    setup(0, 0, 0);
    pulse_go();
    wait_end("basic");
    checks++;
    if (n_starts !== 3) begin errors++; $display("FAIL basic_starts: got %0d expected 3", n_starts); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (start_reg[i] !== 8'(8'h69 + i) || start_data[i] !== ((i == 0) ? 8'h73 : 8'(i))) begin
        errors++;
        $display("FAIL basic_entry%0d: got %h/%h", i, start_reg[i], start_data[i]);
      end
    end
    checks++;
    if (start_cyc[0] - go_cyc !== 3) begin
      errors++; $display("FAIL basic_go_latency: got %0d expected 3", start_cyc[0] - go_cyc);
    end
    checks++;
    if (start_cyc[1] - start_cyc[0] !== 17) begin
      errors++; $display("FAIL basic_gap: got %0d expected 17", start_cyc[1] - start_cyc[0]);
    end
    checks++;
    if ({config_done, config_error, busy} !== 3'b100 || state_out !== 4'd6) begin
      errors++; $display("FAIL basic_status: done/err/busy %b state %0d expected 100 state 6",
                         {config_done, config_error, busy}, state_out);
    end
    checks++;
    if (wr_dev_address !== 6'h29) begin errors++; $display("FAIL basic_dev: got %h expected 29", wr_dev_address); end
  endtask

  task automatic test_retry();
    logic [7:0] exp_reg[5];
    exp_reg = '{8'h69, 8'h6A, 8'h6A, 8'h6A, 8'h6B};
    setup(0, 2, 0);
    pulse_go();
    wait_end("retry");
    checks++;
    if (n_starts !== 5) begin errors++; $display("FAIL retry_starts: got %0d expected 5", n_starts); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (start_reg[i] !== exp_reg[i]) begin
        errors++; $display("FAIL retry_reg%0d: got %h expected %h", i, start_reg[i], exp_reg[i]);
      end
    end
    checks++;
    if (start_data[1] !== 8'h01 || start_data[2] !== 8'h01 || start_data[3] !== 8'h01) begin
      errors++; $display("FAIL retry_data: got %h %h %h expected 01", start_data[1], start_data[2], start_data[3]);
    end
    checks++;
    if (start_cyc[2] - start_cyc[1] !== 15 || start_cyc[4] - start_cyc[3] !== 17) begin
      errors++; $display("FAIL retry_spacing: got %0d/%0d expected 15/17",
                         start_cyc[2] - start_cyc[1], start_cyc[4] - start_cyc[3]);
    end
    checks++;
    if (config_done !== 1'b1 || config_error !== 1'b0) begin
      errors++; $display("FAIL retry_status: done %b err %b expected 1 0", config_done, config_error);
    end
  endtask

  task automatic test_exhaust();
    int n0;
    setup(0, 0, 99);
    pulse_go();
    wait_end("exhaust");
    checks++;
    if (n_starts !== 6) begin errors++; $display("FAIL exhaust_starts: got %0d expected 6", n_starts); end
    checks++;
    if ({config_error, config_done, busy} !== 3'b100 || err_index !== 4'd2 || state_out !== 4'd7) begin
      errors++; $display("FAIL exhaust_status: err/done/busy %b err_index %0d state %0d expected 100 2 7",
                         {config_error, config_done, busy}, err_index, state_out);
    end
    n0 = n_starts;
    repeat (60) @(negedge clk);
    checks++;
    if (n_starts !== n0) begin errors++; $display("FAIL exhaust_quiet: got %0d starts expected %0d", n_starts, n0); end
  endtask

  task automatic test_timeout();
    setup(0, 0, 0);
    never_ack = 1'b1;
    pulse_go();
    wait_end("timeout");
    never_ack = 1'b0;
    checks++;
    if (n_starts !== 4) begin errors++; $display("FAIL timeout_starts: got %0d expected 4", n_starts); end
    checks++;
    if (start_cyc[1] - start_cyc[0] !== 55 || start_cyc[3] - start_cyc[2] !== 55) begin
      errors++; $display("FAIL timeout_spacing: got %0d/%0d expected 55",
                         start_cyc[1] - start_cyc[0], start_cyc[3] - start_cyc[2]);
    end
    checks++;
    if (config_error !== 1'b1 || err_index !== 4'd0) begin
      errors++; $display("FAIL timeout_status: err %b err_index %0d expected 1 0", config_error, err_index);
    end
  endtask

  task automatic test_done_wins();
    setup(0, 0, 0);
    ack_delay = 50;
    pulse_go();
    wait_end("done_wins");
    ack_delay = 10;
    checks++;
    if (n_starts !== 3 || config_done !== 1'b1) begin
      errors++; $display("FAIL done_wins_status: starts %0d done %b expected 3 1", n_starts, config_done);
    end
    checks++;
    if (start_cyc[1] - start_cyc[0] !== 57) begin
      errors++; $display("FAIL done_wins_spacing: got %0d expected 57", start_cyc[1] - start_cyc[0]);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    int n0;
    setup(0, 0, 0);
    pulse_go();
    k = 0;
    while (n_starts < 2 && k < 500) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    checks++;
    if (state_out !== 4'd4 || tbl_index !== 4'd1) begin
      errors++; $display("FAIL midrun_wait: state %0d index %0d expected 4 1", state_out, tbl_index);
    end
    #2;
    reset = 1'b0;
    ack_cnt = -1;
    #1;
    checks++;
    if ({busy, wr_start} !== 2'b00 || state_out !== 4'd0 || tbl_index !== 4'd0 || wr_reg_address !== 8'h00) begin
      errors++; $display("FAIL midrun_reset: busy/start %b state %0d index %0d reg %h expected 0",
                         {busy, wr_start}, state_out, tbl_index, wr_reg_address);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    n0 = n_starts;
    repeat (3) @(negedge clk);
    checks++;
    if (n_starts !== n0 || state_out !== 4'd0) begin
      errors++; $display("FAIL midrun_release: starts %0d state %0d expected %0d 0", n_starts, state_out, n0);
    end
    setup(0, 0, 0);
    pulse_go();
    repeat (4) @(negedge clk);
    pulse_go();
    wait_end("restart");
    checks++;
    if (n_starts !== 3 || start_reg[0] !== 8'h69 || start_reg[2] !== 8'h6B || config_done !== 1'b1) begin
      errors++; $display("FAIL restart_run: starts %0d first %h last %h done %b expected 3 69 6B 1",
                         n_starts, start_reg[0], start_reg[2], config_done);
    end
  endtask

  initial begin
    reset = 1'b0;
    go = 1'b0;
    setup(0, 0, 0);
    repeat (2) @(negedge clk);
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    test_basic();
    test_retry();
    test_exhaust();
    test_timeout();
    test_done_wins();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
